// File: rtl/test_pkg.sv
// test_pkg: shared counter width, reset values and value type for the counter smoke-test block.
package test_pkg;
    localparam int CNT_W = 4;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_UP_INIT = 4'h0;
    localparam cnt_t CNT_DN_INIT = 4'hF;
endpackage

// File: rtl/step_counter.sv
// step_counter: free-running modulo-2^WIDTH counter stepping up (DIR=0) or down (DIR=1) each rising clk.
module step_counter #(
    parameter int              WIDTH = 4,
    parameter logic [WIDTH-1:0] INIT = '0,
    parameter int              STEP  = 1,
    parameter bit              DIR   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] q
);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    // Declaration value gives the power-on state so an unreset run still starts at INIT.
    logic [WIDTH-1:0] cnt_q = INIT;
    logic [WIDTH-1:0] cnt_d;
    always_comb begin
        cnt_d = DIR ? cnt_q - STEP_W : cnt_q + STEP_W;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= INIT;
        else     cnt_q <= cnt_d;
    end
    assign q = cnt_q;
endmodule

// File: rtl/test_counters.sv
// test_counters: complementary up/down 4-bit counter pair; with default values OUT1 + OUT2 stays 4'hF.
module test_counters
    import test_pkg::*;
#(
    parameter int               WIDTH   = CNT_W,
    parameter logic [WIDTH-1:0] UP_INIT = CNT_UP_INIT,
    parameter logic [WIDTH-1:0] DN_INIT = CNT_DN_INIT,
    parameter int               STEP    = 1
) (
    input  logic             CLK,
    input  logic             RST,
    output logic [WIDTH-1:0] OUT1,
    output logic [WIDTH-1:0] OUT2
);
    step_counter #(.WIDTH(WIDTH), .INIT(UP_INIT), .STEP(STEP), .DIR(1'b0)) u_up (
        .clk(CLK), .rst(RST), .q(OUT1)
    );
    step_counter #(.WIDTH(WIDTH), .INIT(DN_INIT), .STEP(STEP), .DIR(1'b1)) u_dn (
        .clk(CLK), .rst(RST), .q(OUT2)
    );
endmodule

// File: tb/tb_test_counters.sv
// tb_test_counters: scoreboard bench; expected counts derive from edges seen since the last reset.
module tb_test_counters;
    typedef struct {
        string      name;
        logic [3:0] up;
        logic [3:0] dn;
    } exp_t;
    logic       clk;
    logic       rst;
    logic [3:0] out1;
    logic [3:0] out2;
    exp_t       sb[$];
    int         n_edges;
    int         checks;
    int         passed;

    test_counters dut (.CLK(clk), .RST(rst), .OUT1(out1), .OUT2(out2));

    initial begin
        clk = 1'b0;
        forever #100 clk = ~clk;
    end

    // Reference: counts are simply the number of unreset rising edges, mod 16.
    initial n_edges = 0;
    always @(posedge clk) if (!rst) n_edges = n_edges + 1;
    always @(posedge rst) n_edges = 0;

    task automatic push(input string name);
        exp_t e;
        e.name = name;
        e.up   = 4'((0 + n_edges) % 16);
        e.dn   = 4'((15 - (n_edges % 16) + 16) % 16);
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    initial begin
        exp_t e;
        checks = 0;
        passed = 0;
        forever begin
            wait (sb.size() != 0);
            e = sb.pop_front();
            chk({e.name, "_out1"}, out1, e.up);
            chk({e.name, "_out2"}, out2, e.dn);
            chk({e.name, "_sum"}, 4'(out1 + out2), 4'hF);
        end
    end

    task automatic mid_pulse(input string name);
        #20 rst = 1'b1;
        #10 push(name);
        #20 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        #50 push("poweron");
        repeat (16) begin
            @(negedge clk);
            push(n_edges <= 7 ? "count" : (n_edges == 16 ? "wrap" : "count_hi"));
        end
        @(negedge clk);
        mid_pulse("rst_clear");
        repeat (5) begin
            @(negedge clk);
            push("pre_async");
        end
        @(negedge clk);
        push("at_five");
        mid_pulse("async_rst");
        @(negedge clk);
        push("resume");
        @(negedge clk);
        rst = 1'b1;
        #10 push("held_start");
        repeat (4) begin
            @(negedge clk);
            push("rst_held");
        end
        rst = 1'b0;
        @(negedge clk);
        push("after_held");
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) mid_pulse("rand_rst");
            else push("rand");
        end
        #10;
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
